// File: rtl/ifft_stream_out.sv
// rtl/ifft_stream_out.sv - IFFT pair output adapter: convergent round/saturate, pair FIFO, one-sample-per-beat stream.
module ifft_stream_out #(
  parameter int IWIDTH = 21,
  parameter int OWIDTH = 16,
  parameter int LGSIZE = 11,
  parameter int LGFIFO = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ce,
  input  logic [2*IWIDTH-1:0]   i_left,
  input  logic [2*IWIDTH-1:0]   i_right,
  input  logic                  i_sync,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2*OWIDTH-1:0]   o_data,
  output logic                  o_last,
  output logic                  o_overflow,
  output logic                  o_sync_err
);

  localparam int D  = IWIDTH - OWIDTH;
  localparam int EW = 4*OWIDTH + 1;

  logic [IWIDTH-1:0] rin  [4];
  logic [OWIDTH-1:0] rout [4];

  assign rin[0] = i_left[2*IWIDTH-1:IWIDTH];
  assign rin[1] = i_left[IWIDTH-1:0];
  assign rin[2] = i_right[2*IWIDTH-1:IWIDTH];
  assign rin[3] = i_right[IWIDTH-1:0];

  generate
    if (D == 0) begin : g_pass
      for (genvar g = 0; g < 4; g++) begin : g_c
        assign rout[g] = rin[g];
      end
    end else begin : g_rnd
      localparam logic [D-1:0] HALF = D'(1) << (D-1);
      for (genvar g = 0; g < 4; g++) begin : g_c
        logic [D-1:0]  frac;
        logic          up;
        logic [OWIDTH:0] top;
        assign frac = rin[g][D-1:0];
        // exact half rounds up only when the kept LSB is odd, landing on even
        assign up   = (frac > HALF) || ((frac == HALF) && rin[g][D]);
        assign top  = {rin[g][IWIDTH-1], rin[g][IWIDTH-1:D]} + {{OWIDTH{1'b0}}, up};
        assign rout[g] = (top[OWIDTH] != top[OWIDTH-1])
                       ? {top[OWIDTH], {(OWIDTH-1){~top[OWIDTH]}}}
                       : top[OWIDTH-1:0];
      end
    end
  endgenerate

  logic [LGSIZE-2:0]   wpair_q, wpair_d, pair_idx;
  logic                started_q, started_d;
  logic                s1_valid_q, s1_valid_d;
  logic [2*OWIDTH-1:0] s1_left_q, s1_left_d, s1_right_q, s1_right_d;
  logic                s1_last_q, s1_last_d;
  logic [LGFIFO:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                half_q, half_d;
  logic                o_valid_q, o_valid_d, o_last_q, o_last_d;
  logic [2*OWIDTH-1:0] o_data_q, o_data_d;
  logic                ovf_q, ovf_d, serr_q, serr_d;
  logic [EW-1:0]       mem_q [2**LGFIFO];
  logic [EW-1:0]       head;
  logic                accept, full, hs, pop, wr_en;

  always_comb begin
    accept   = i_ce && (started_q || i_sync);
    pair_idx = i_sync ? '0 : wpair_q;
    wpair_d    = wpair_q;
    started_d  = started_q;
    serr_d     = serr_q;
    s1_valid_d = accept;
    s1_left_d  = s1_left_q;
    s1_right_d = s1_right_q;
    s1_last_d  = s1_last_q;
    if (accept) begin
      wpair_d    = i_sync ? {{(LGSIZE-2){1'b0}}, 1'b1} : wpair_q + 1'b1;
      started_d  = 1'b1;
      serr_d     = serr_q | (i_sync && started_q && (wpair_q != '0));
      s1_left_d  = {rout[0], rout[1]};
      s1_right_d = {rout[2], rout[3]};
      s1_last_d  = (pair_idx == {(LGSIZE-1){1'b1}});
    end

    // a pop in this cycle makes room for a write even at full occupancy
    full  = (wr_ptr_q[LGFIFO] != rd_ptr_q[LGFIFO]) &&
            (wr_ptr_q[LGFIFO-1:0] == rd_ptr_q[LGFIFO-1:0]);
    hs    = o_valid_q && i_ready;
    pop   = hs && half_q;
    wr_en = s1_valid_q && (!full || pop);
    ovf_d = ovf_q | (s1_valid_q && full && !pop);
    wr_ptr_d = wr_ptr_q + {{LGFIFO{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{LGFIFO{1'b0}}, pop};
    half_d   = hs ? ~half_q : half_q;

    // presentation register follows the post-handshake head of already-written entries
    head      = mem_q[rd_ptr_d[LGFIFO-1:0]];
    o_valid_d = (rd_ptr_d != wr_ptr_q);
    o_data_d  = '0;
    o_last_d  = 1'b0;
    if (o_valid_d) begin
      o_data_d = half_d ? head[2*OWIDTH:1] : head[EW-1:2*OWIDTH+1];
      o_last_d = head[0] && half_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q[LGFIFO-1:0]] <= {s1_left_q, s1_right_q, s1_last_q};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wpair_q    <= '0;
      started_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_left_q  <= '0;
      s1_right_q <= '0;
      s1_last_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      half_q     <= 1'b0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_last_q   <= 1'b0;
      ovf_q      <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      wpair_q    <= wpair_d;
      started_q  <= started_d;
      s1_valid_q <= s1_valid_d;
      s1_left_q  <= s1_left_d;
      s1_right_q <= s1_right_d;
      s1_last_q  <= s1_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      half_q     <= half_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_last_q   <= o_last_d;
      ovf_q      <= ovf_d;
      serr_q     <= serr_d;
    end
  end

  assign o_valid    = o_valid_q;
  assign o_data     = o_data_q;
  assign o_last     = o_last_q;
  assign o_overflow = ovf_q;
  assign o_sync_err = serr_q;

endmodule

// File: tb/tb_ifft_stream_out.sv
// tb/tb_ifft_stream_out.sv - scoreboard bench for ifft_stream_out.
module tb_ifft_stream_out;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_ce = 1'b0;
  logic [41:0] i_left = '0;
  logic [41:0] i_right = '0;
  logic        i_sync = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_data;
  logic        o_last;
  logic        o_overflow;
  logic        o_sync_err;

  ifft_stream_out dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_left(i_left), .i_right(i_right),
    .i_sync(i_sync), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_last(o_last), .o_overflow(o_overflow), .o_sync_err(o_sync_err)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];
  bit m_started = 0;
  int m_wpair = 0;

  int rv[16] = '{33, 49, 47, 112, -48, -80, -49, -1,
                 1048575, -1048576, 1048559, 1048560, -1048560, 0, 16, 17};
  int ev[16] = '{1, 2, 1, 4, -2, -2, -2, 0,
                 32767, -32768, 32767, 32767, -32768, 0, 0, 1};

  function automatic logic [41:0] cin(input int re, input int im);
    logic [20:0] a, b;
    a = re[20:0];
    b = im[20:0];
    return {a, b};
  endfunction

  function automatic logic [31:0] co(input int re, input int im);
    logic [15:0] a, b;
    a = re[15:0];
    b = im[15:0];
    return {a, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [41:0] l, input logic [41:0] r, input logic s,
                      input logic [31:0] el, input logic [31:0] er, input bit store);
    int idx;
    i_left = l;
    i_right = r;
    i_sync = s;
    i_ce = 1'b1;
    if (m_started || s) begin
      idx = s ? 0 : m_wpair;
      m_wpair = s ? 1 : (m_wpair + 1) % 1024;
      m_started = 1;
      if (store) begin
        exp_q.push_back({el, 1'b0});
        exp_q.push_back({er, idx == 1023});
      end
    end
    tick();
    i_ce = 1'b0;
    i_sync = 1'b0;
  endtask

  task automatic ramp(input int p, input logic s, input bit store, input bit gap);
    send(cin(p*32, -p*32), cin((p+4096)*32, -(p+4096)*32), s,
         co(p, -p), co(p+4096, -(p+4096)), store);
    if (gap) tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) tick();
    chk("drain_remaining", exp_q.size(), 0);
  endtask

  always @(negedge i_clk) begin
    if (!i_reset && o_valid && i_ready) begin
      logic [32:0] e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got data %h last %b, expected no beat", o_data, o_last);
      end else begin
        e = exp_q.pop_front();
        if ({o_data, o_last} !== e) begin
          n_err++;
          $display("FAIL beat: got data %h last %b, expected data %h last %b",
                   o_data, o_last, e[32:1], e[0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("reset_valid", o_valid, 0);
    chk("reset_data", o_data, 0);
    chk("reset_last", o_last, 0);
    chk("reset_flags", {o_overflow, o_sync_err}, 0);
    tick(); tick();
    i_reset = 1'b0;
    tick();

    // unsynced pairs are discarded, then the synced pair starts the frame
    for (int k = 0; k < 3; k++) ramp(k + 7, 1'b0, 1, 1);
    send(cin(48, 16), cin(80, -16), 1'b1, co(2, 0), co(2, 0), 1);
    chk("valid_after_t", o_valid, 0);
    tick();
    chk("valid_after_t1", o_valid, 0);
    tick();
    chk("valid_after_t2", o_valid, 1);

    // rounding and saturation vectors as frame pairs 1..4
    for (int p = 0; p < 4; p++) begin
      send(cin(rv[4*p], rv[4*p+1]), cin(rv[4*p+2], rv[4*p+3]), 1'b0,
           co(ev[4*p], ev[4*p+1]), co(ev[4*p+2], ev[4*p+3]), 1);
      tick();
    end
    for (int p = 5; p < 1024; p++) ramp(p, 1'b0, 1, 1);
    drain();
    chk("frame_sync_err", o_sync_err, 0);
    chk("frame_overflow", o_overflow, 0);

    // backpressure burst: only the first 16 pairs fit
    i_ready = 1'b0;
    for (int p = 0; p < 40; p++) ramp(p, p == 0, p < 16, 0);
    for (int k = 0; k < 40; k++) tick();
    chk("overflow_set", o_overflow, 1);
    i_ready = 1'b1;
    for (int p = 40; p < 1024; p++) ramp(p, 1'b0, 1, 1);
    drain();
    chk("ovf_sync_err", o_sync_err, 0);

    // misplaced sync at pair index 300 restarts the frame count
    for (int p = 0; p < 300; p++) ramp(p, p == 0, 1, 1);
    chk("sync_err_before", o_sync_err, 0);
    ramp(300, 1'b1, 1, 1);
    chk("sync_err_set", o_sync_err, 1);
    for (int p = 301; p < 1324; p++) ramp(p, 1'b0, 1, 1);
    drain();

    // asynchronous reset while draining
    for (int p = 0; p < 12; p++) ramp(p, p == 0, 1, 0);
    tick();
    chk("drain_in_progress", o_valid, 1);
    #2;
    i_reset = 1'b1;
    exp_q.delete();
    m_started = 0;
    m_wpair = 0;
    #1;
    chk("async_valid", o_valid, 0);
    chk("async_data", o_data, 0);
    chk("async_last", o_last, 0);
    chk("async_flags", {o_overflow, o_sync_err}, 0);
    tick(); tick();
    i_reset = 1'b0;
    for (int p = 0; p < 3; p++) ramp(p + 50, 1'b0, 1, 1);
    for (int k = 0; k < 5; k++) tick();
    chk("post_reset_idle", o_valid, 0);
    for (int p = 0; p < 4; p++) ramp(p, p == 0, 1, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
